// File: rtl/bcd_seq_conv_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// Master requests conversions; slave is the converter.
interface bcd_seq_conv_if #(
  parameter int BIN_W  = 6,
  parameter int DIGITS = 2
);
  logic                start;
  logic [BIN_W-1:0]    bin;
  logic                ready;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                ovf;

  modport master (
    output start, bin,
    input  ready, busy, done, bcd, ovf
  );

  modport slave (
    input  start, bin,
    output ready, busy, done, bcd, ovf
  );
endinterface

// File: rtl/bcd_seq_conv.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock.
// Out-of-range inputs saturate to all nines with ovf set.
module bcd_seq_conv #(
  parameter int BIN_W  = 6,
  parameter int DIGITS = 2
) (
  input  logic clk,
  input  logic rst_n,
  bcd_seq_conv_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [31:0] MAXV = 32'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [BIN_W-1:0] sreg;
  logic [W-1:0]     wreg;
  logic [W-1:0]     adj;
  logic [W+BIN_W-1:0] shf;
  logic [CW-1:0]    cnt;
  logic             ovf_p;
  logic [W-1:0]     bcd_q;
  logic             ovf_q;
  logic             accept;
  logic             last;

  // Add-3 on every digit >= 5, then shift digits and binary left as one word
  always_comb begin
    adj = wreg;
    for (int i = 0; i < DIGITS; i++) begin
      if (wreg[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = wreg[4*i +: 4] + 4'd3;
    end
    shf = {adj, sreg} << 1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next state plus accept/last-iteration strobes
  always_comb begin
    nxt    = state;
    accept = 1'b0;
    last   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          nxt    = CONV;
          accept = 1'b1;
        end else begin
          nxt = IDLE;
        end
      end
      CONV: begin
        if (cnt == CW'(1)) begin
          nxt  = DONE;
          last = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Datapath: latch on accept, iterate in CONV, publish on the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg  <= '0;
      wreg  <= '0;
      cnt   <= '0;
      ovf_p <= 1'b0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      sreg  <= bus.bin;
      wreg  <= '0;
      cnt   <= CW'(BIN_W);
      ovf_p <= 32'(bus.bin) > MAXV;
    end else if (state == CONV) begin
      {wreg, sreg} <= shf;
      cnt          <= cnt - CW'(1);
      if (last) begin
        bcd_q <= ovf_p ? {DIGITS{4'h9}}
                       : shf[W+BIN_W-1 -: W];
        ovf_q <= ovf_p;
      end
    end
  end

  assign bus.ready = (state != CONV);
  assign bus.busy  = (state == CONV);
  assign bus.done  = (state == DONE);
  assign bus.bcd   = bcd_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_bcd_seq_conv.sv
// Bench for bcd_seq_conv: three parameterisations on one clock,
// checked against a decimal-digit reference model.
module tb_bcd_seq_conv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_seq_conv_if #(.BIN_W(6),  .DIGITS(2)) if0();
  bcd_seq_conv_if #(.BIN_W(7),  .DIGITS(2)) if1();
  bcd_seq_conv_if #(.BIN_W(20), .DIGITS(6)) if2();

  bcd_seq_conv #(.BIN_W(6),  .DIGITS(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  bcd_seq_conv #(.BIN_W(7),  .DIGITS(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  bcd_seq_conv #(.BIN_W(20), .DIGITS(6)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  bit          d_start [3];
  logic [31:0] d_bin   [3];
  logic        r_ready [3];
  logic        r_busy  [3];
  logic        r_done  [3];
  logic        r_ovf   [3];
  logic [23:0] r_bcd   [3];

  assign if0.start = d_start[0];
  assign if1.start = d_start[1];
  assign if2.start = d_start[2];
  assign if0.bin   = d_bin[0][5:0];
  assign if1.bin   = d_bin[1][6:0];
  assign if2.bin   = d_bin[2][19:0];

  assign r_ready[0] = if0.ready;
  assign r_ready[1] = if1.ready;
  assign r_ready[2] = if2.ready;
  assign r_busy[0]  = if0.busy;
  assign r_busy[1]  = if1.busy;
  assign r_busy[2]  = if2.busy;
  assign r_done[0]  = if0.done;
  assign r_done[1]  = if1.done;
  assign r_done[2]  = if2.done;
  assign r_ovf[0]   = if0.ovf;
  assign r_ovf[1]   = if1.ovf;
  assign r_ovf[2]   = if2.ovf;
  assign r_bcd[0]   = 24'(if0.bcd);
  assign r_bcd[1]   = 24'(if1.bcd);
  assign r_bcd[2]   = 24'(if2.bcd);

  int binw [3] = '{6, 7, 20};
  int digs [3] = '{2, 2, 6};

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic int lim_of(input int dg);
    int l = 1;
    for (int i = 0; i < dg; i++) l *= 10;
    return l;
  endfunction

  // Reference: decimal digits of v, saturated to nines when out of range
  function automatic logic [23:0] ref_bcd(input int v, input int dg);
    logic [23:0] r = '0;
    int x = v;
    if (v >= lim_of(dg)) begin
      for (int i = 0; i < dg; i++) r[4*i +: 4] = 4'd9;
    end else begin
      for (int i = 0; i < dg; i++) begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  // One pulsed-start conversion; returns at the negedge inside the done cycle
  task automatic conv(input int s, input int b, output int busyc,
                      output logic [23:0] rb, output logic ro,
                      output bit held, output bit ok);
    logic [23:0] pre;
    @(negedge clk);
    pre = r_bcd[s];
    d_bin[s] = 32'(b);
    d_start[s] = 1'b1;
    @(negedge clk);
    d_start[s] = 1'b0;
    busyc = 0;
    ok = 0;
    held = 1;
    rb = '0;
    ro = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (r_done[s]) begin
        ok = 1;
        rb = r_bcd[s];
        ro = r_ovf[s];
        break;
      end
      if (r_busy[s]) begin
        busyc++;
        if (r_bcd[s] !== pre) held = 0;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    int          sel;
    int          bin;
    logic [23:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vt [10];

  initial begin
    int          bc;
    logic [23:0] rb;
    logic        ro;
    bit          held;
    bit          ok;
    int          dq [$];
    int          ndone;
    bit          pd;

    for (int i = 0; i < 3; i++) begin
      d_start[i] = 1'b0;
      d_bin[i]   = '0;
    end

    vt[0] = '{0, 37,      24'h000037, 1'b0};
    vt[1] = '{0, 0,       24'h000000, 1'b0};
    vt[2] = '{0, 63,      24'h000063, 1'b0};
    vt[3] = '{1, 127,     24'h000099, 1'b1};
    vt[4] = '{1, 99,      24'h000099, 1'b0};
    vt[5] = '{1, 100,     24'h000099, 1'b1};
    vt[6] = '{2, 0,       24'h000000, 1'b0};
    vt[7] = '{2, 999999,  24'h999999, 1'b0};
    vt[8] = '{2, 1000000, 24'h999999, 1'b1};
    vt[9] = '{2, 1048575, 24'h999999, 1'b1};

    #12;
    for (int s = 0; s < 3; s++) begin
      chk("rst_ready", 32'(r_ready[s]), 1);
      chk("rst_busy",  32'(r_busy[s]),  0);
      chk("rst_done",  32'(r_done[s]),  0);
      chk("rst_bcd",   32'(r_bcd[s]),   0);
      chk("rst_ovf",   32'(r_ovf[s]),   0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      conv(vt[v].sel, vt[v].bin, bc, rb, ro, held, ok);
      chk("vec_timeout", 32'(ok), 1);
      chk("vec_bcd", 32'(rb), 32'(vt[v].bcd));
      chk("vec_ovf", 32'(ro), 32'(vt[v].ovf));
      chk("vec_busy_len", 32'(bc), 32'(binw[vt[v].sel]));
      chk("vec_bcd_held", 32'(held), 1);
      @(negedge clk);
      chk("vec_done_1cyc", 32'(r_done[vt[v].sel]), 0);
      chk("vec_ready_after", 32'(r_ready[vt[v].sel]), 1);
    end

    // Start during busy is ignored: one done pulse, first result kept
    @(negedge clk);
    d_bin[0] = 21;
    d_start[0] = 1'b1;
    @(negedge clk);
    d_bin[0] = 50;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    d_start[0] = 1'b0;
    ndone = 0;
    rb = '0;
    for (int i = 0; i < 15; i++) begin
      if (r_done[0]) begin
        ndone++;
        rb = r_bcd[0];
      end
      @(negedge clk);
    end
    chk("ign_ndone", 32'(ndone), 1);
    chk("ign_bcd", 32'(rb), 32'h21);

    // Start held high: back-to-back conversions every BIN_W+1 cycles
    d_bin[0] = 45;
    d_start[0] = 1'b1;
    ndone = 0;
    pd = 0;
    for (int i = 0; i < 40; i++) begin
      if (pd) chk("b2b_busy_after_done", 32'(r_busy[0]), 1);
      pd = r_done[0];
      if (r_done[0]) begin
        dq.push_back(i);
        chk("b2b_bcd", 32'(r_bcd[0]), 32'h45);
        ndone++;
        if (ndone == 3) begin
          d_start[0] = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    chk("b2b_ndone", 32'(ndone), 3);
    if (dq.size() >= 3) begin
      chk("b2b_period1", 32'(dq[1] - dq[0]), 7);
      chk("b2b_period2", 32'(dq[2] - dq[1]), 7);
    end
    @(negedge clk);

    // Reset in the third busy cycle aborts with no done pulse
    @(negedge clk);
    d_bin[0] = 59;
    d_start[0] = 1'b1;
    @(negedge clk);
    d_start[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_pre", 32'(r_busy[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(r_ready[0]), 1);
    chk("abort_busy",  32'(r_busy[0]),  0);
    chk("abort_done",  32'(r_done[0]),  0);
    chk("abort_bcd",   32'(r_bcd[0]),   0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (r_done[0]) ndone++;
      @(negedge clk);
    end
    chk("abort_nodone", 32'(ndone), 0);
    chk("abort_ready_after", 32'(r_ready[0]), 1);
    chk("abort_bcd_after", 32'(r_bcd[0]), 0);

    // Start accepted on the first edge after reset release
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    d_bin[0] = 9;
    d_start[0] = 1'b1;
    @(negedge clk);
    d_start[0] = 1'b0;
    chk("first_edge_busy", 32'(r_busy[0]), 1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (r_done[0]) begin
        ok = 1;
        chk("first_edge_bcd", 32'(r_bcd[0]), 32'h09);
        break;
      end
      @(negedge clk);
    end
    chk("first_edge_timeout", 32'(ok), 1);

    // Random sweep on every instance against the reference model
    for (int s = 0; s < 3; s++) begin
      int n = (s == 2) ? 1000 : 60;
      int mx = (1 << binw[s]) - 1;
      for (int k = 0; k < n; k++) begin
        int b = int'($urandom_range(0, mx));
        conv(s, b, bc, rb, ro, held, ok);
        chk("rnd_timeout", 32'(ok), 1);
        chk("rnd_bcd", 32'(rb), 32'(ref_bcd(b, digs[s])));
        chk("rnd_ovf", 32'(ro), 32'(b >= lim_of(digs[s])));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
